sap_control_sequencer: RTL and testbench
========================================

Name: sap_control_sequencer

Overview:
Microcoded control sequencer for the SAP-U datapath (registers A/B, ALU, RAM/MAR, bus).
- Holds a microstep counter (T0..T(STEPS-1)).
- Decodes the 4-bit opcode from the instruction register into one-hot control strobes for the bus drivers and loaders.
- Handles fetch, execute and halt.
- Sits between the top-level clock/reset and all datapath control inputs; replaces manual strobe driving.

Parameters:
STEPS, 5, microsteps per instruction when the skip feature is off; legal 5..8. Step counter width is fixed at 3 bits.

Ports:
clk  input  1  system clock; all state changes on rising edge
reset  input  1  synchronous, active-high reset
run  input  1  1 = advance one microstep per clock; 0 = stall
opcode  input  4  IR upper nibble; valid from T2 onward
step  output  3  current microstep
halted  output  1  set by HLT; cleared only by reset
pc_out  output  1  program counter drives bus
pc_inc  output  1  program counter increment
pc_load  output  1  program counter loads from bus
mar_load  output  1  maps to ram_load_mar_reg
ram_out  output  1  maps to ram_output_enable
ram_write_enable  output  1  RAM write strobe
ir_load  output  1  instruction register load
ir_out  output  1  IR lower nibble drives bus
reg_a_load  output  1  register A load
reg_a_enable  output  1  register A drives bus
reg_b_load  output  1  register B load
alu_enable  output  1  ALU drives bus
alu_subtract  output  1  ALU subtract select
out_load  output  1  output register load

Behaviour:
- State: step (3b) and halted (1b). Control outputs are a combinational decode of step, opcode and halted, gated by active = run & ~halted & ~reset.
- Reset (sync): next edge gives step=0, halted=0. While reset=1, all control outputs are 0. Reset mid-instruction aborts it; no partial strobes after the edge.
- run=0: step holds and all control outputs are 0. run is sampled every clock.
- halted=1: step frozen and all control outputs are 0, regardless of run.
- Fetch, all opcodes:
  - T0: pc_out, mar_load.
  - T1: ram_out, ir_load, pc_inc.
- Execute (T2..T4), by opcode:
  - 0x0 NOP: none.
  - 0x1 LDA: T2 ir_out+mar_load; T3 ram_out+reg_a_load.
  - 0x2 ADD: T2 ir_out+mar_load; T3 ram_out+reg_b_load; T4 alu_enable+reg_a_load.
  - 0x3 SUB: as ADD; T4 also alu_subtract.
  - 0x4 STA: T2 ir_out+mar_load; T3 reg_a_enable+ram_write_enable.
  - 0x5 LDI: T2 ir_out+reg_a_load.
  - 0x6 JMP: T2 ir_out+pc_load.
  - 0xE OUT: T2 reg_a_enable+out_load.
  - 0xF HLT: T2 no strobes; halted sets at end of T2 (if active).
  - Others: treated as NOP.
- Steps T5..T(STEPS-1) are always empty.
- Step advance, when active: step <= (step == STEPS-1) ? 0 : step+1. Wrap is T(STEPS-1) -> T0, no gap cycle.
- Invariant: at most one bus driver per cycle among pc_out, ram_out, ir_out, reg_a_enable, alu_enable. ram_write_enable never coincides with ram_out.
- alu_subtract is asserted only together with alu_enable.

Optional Feature:
Macro SAP_SEQ_SKIP_EN.
- Defined: after the last active step of the decoded opcode, step returns to T0 at the next active edge.
  - Last step: LDA/STA = T3; ADD/SUB = T4; LDI/JMP/OUT/NOP/undefined = T2.
  - HLT halts at T2; step stays 2.
  - Skip decisions are made only at step >= 2; T0 and T1 always advance.
- Not defined: fixed STEPS-cycle instructions as in Behaviour.

Test Plan:
- Reset: reset=1 for 2 clocks with run=1 -> step=0, halted=0, all strobes 0 during reset. First cycle after release: pc_out=mar_load=1.
- LDA, opcode=0x1, run=1, STEPS=5 -> strobes match the table per step; reg_a_load only at step=3; step sequence 0,1,2,3,4,0.
- SUB, opcode=0x3 -> step=4 has alu_enable=alu_subtract=reg_a_load=1; alu_subtract=0 at every other step; one-hot bus-driver check passes every cycle.
- HLT, opcode=0xF -> halted=1 after the step=2 edge; step stays 2 and all strobes stay 0 for 20 clocks. Then reset=1 -> step=0, halted=0.
- Stall/reset mid-op: ADD at step=3, run=0 for 3 clocks -> step holds 3, strobes 0; run=1 resumes at step=3. Then reset at step=4 -> next cycle step=0, no alu_enable.
- With SAP_SEQ_SKIP_EN: opcodes LDI, then LDA, then ADD -> step sequences 0,1,2 | 0,1,2,3 | 0,1,2,3,4 back to back with no gap cycles.

Source files
------------

// File: rtl/sap_control_sequencer.sv
// Microcoded control sequencer for the SAP-U datapath: microstep counter, opcode decode, halt latch.
// Optional early return to T0 after an instruction's last active step: define SAP_SEQ_SKIP_EN.
module sap_control_sequencer #(
  parameter int STEPS = 5
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       run,
  input  logic [3:0] opcode,
  output logic [2:0] step,
  output logic       halted,
  output logic       pc_out,
  output logic       pc_inc,
  output logic       pc_load,
  output logic       mar_load,
  output logic       ram_out,
  output logic       ram_write_enable,
  output logic       ir_load,
  output logic       ir_out,
  output logic       reg_a_load,
  output logic       reg_a_enable,
  output logic       reg_b_load,
  output logic       alu_enable,
  output logic       alu_subtract,
  output logic       out_load
);

  typedef enum logic [2:0] {T0, T1, T2, T3, T4, T5, T6, T7} step_t;

  localparam logic [3:0] OP_LDA = 4'h1;
  localparam logic [3:0] OP_ADD = 4'h2;
  localparam logic [3:0] OP_SUB = 4'h3;
  localparam logic [3:0] OP_STA = 4'h4;
  localparam logic [3:0] OP_LDI = 4'h5;
  localparam logic [3:0] OP_JMP = 4'h6;
  localparam logic [3:0] OP_OUT = 4'hE;
  localparam logic [3:0] OP_HLT = 4'hF;

  localparam step_t LAST_STEP = step_t'(STEPS - 1);

  step_t step_reg, step_next;
  logic  halted_reg, halted_next;
  logic  active;
  logic  wrap;

  assign active = run & ~halted_reg & ~reset;
  assign step   = step_reg;
  assign halted = halted_reg;

`ifdef SAP_SEQ_SKIP_EN
  step_t op_last;

  always_comb begin
    op_last = T2;
    case (opcode)
      OP_LDA, OP_STA: op_last = T3;
      OP_ADD, OP_SUB: op_last = T4;
      default:        op_last = T2;
    endcase
  end

  // T0/T1 never skip because op_last is at least T2.
  assign wrap = (step_reg == op_last) || (step_reg == LAST_STEP);
`else
  assign wrap = (step_reg == LAST_STEP);
`endif

  always_ff @(posedge clk) begin
    if (reset) begin
      step_reg   <= T0;
      halted_reg <= 1'b0;
    end else begin
      step_reg   <= step_next;
      halted_reg <= halted_next;
    end
  end

  // HLT freezes the counter at T2 on the same edge that sets halted.
  always_comb begin
    step_next   = step_reg;
    halted_next = halted_reg;
    if (active) begin
      if (step_reg == T2 && opcode == OP_HLT) begin
        halted_next = 1'b1;
      end else if (wrap) begin
        step_next = T0;
      end else begin
        step_next = step_t'(step_reg + 3'd1);
      end
    end
  end

  always_comb begin
    pc_out           = 1'b0;
    pc_inc           = 1'b0;
    pc_load          = 1'b0;
    mar_load         = 1'b0;
    ram_out          = 1'b0;
    ram_write_enable = 1'b0;
    ir_load          = 1'b0;
    ir_out           = 1'b0;
    reg_a_load       = 1'b0;
    reg_a_enable     = 1'b0;
    reg_b_load       = 1'b0;
    alu_enable       = 1'b0;
    alu_subtract     = 1'b0;
    out_load         = 1'b0;
    if (active) begin
      case (step_reg)
        T0: begin
          pc_out   = 1'b1;
          mar_load = 1'b1;
        end
        T1: begin
          ram_out = 1'b1;
          ir_load = 1'b1;
          pc_inc  = 1'b1;
        end
        T2: begin
          case (opcode)
            OP_LDA, OP_ADD, OP_SUB, OP_STA: begin
              ir_out   = 1'b1;
              mar_load = 1'b1;
            end
            OP_LDI: begin
              ir_out     = 1'b1;
              reg_a_load = 1'b1;
            end
            OP_JMP: begin
              ir_out  = 1'b1;
              pc_load = 1'b1;
            end
            OP_OUT: begin
              reg_a_enable = 1'b1;
              out_load     = 1'b1;
            end
            default: ;
          endcase
        end
        T3: begin
          case (opcode)
            OP_LDA: begin
              ram_out    = 1'b1;
              reg_a_load = 1'b1;
            end
            OP_ADD, OP_SUB: begin
              ram_out    = 1'b1;
              reg_b_load = 1'b1;
            end
            OP_STA: begin
              reg_a_enable     = 1'b1;
              ram_write_enable = 1'b1;
            end
            default: ;
          endcase
        end
        T4: begin
          if (opcode == OP_ADD || opcode == OP_SUB) begin
            alu_enable   = 1'b1;
            reg_a_load   = 1'b1;
            alu_subtract = (opcode == OP_SUB);
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_sap_control_sequencer.sv
// Directed bench for sap_control_sequencer: reset, LDA/SUB tables, HLT freeze, stall/reset mid-op, back-to-back LDI/LDA/ADD.
// Expected step counts follow SAP_SEQ_SKIP_EN when the bench is built with it.
module tb_sap_control_sequencer;

  logic       clk = 1'b0;
  logic       reset, run;
  logic [3:0] opcode;
  logic [2:0] step;
  logic       halted;
  logic       pc_out, pc_inc, pc_load, mar_load, ram_out, ram_write_enable, ir_load, ir_out;
  logic       reg_a_load, reg_a_enable, reg_b_load, alu_enable, alu_subtract, out_load;

  int checks = 0;
  int failures = 0;

  sap_control_sequencer #(.STEPS(5)) dut (
    .clk(clk), .reset(reset), .run(run), .opcode(opcode), .step(step), .halted(halted),
    .pc_out(pc_out), .pc_inc(pc_inc), .pc_load(pc_load), .mar_load(mar_load),
    .ram_out(ram_out), .ram_write_enable(ram_write_enable), .ir_load(ir_load), .ir_out(ir_out),
    .reg_a_load(reg_a_load), .reg_a_enable(reg_a_enable), .reg_b_load(reg_b_load),
    .alu_enable(alu_enable), .alu_subtract(alu_subtract), .out_load(out_load)
  );

  always #5 clk = ~clk;

  // Strobe bit positions in the packed observation vector
  localparam logic [13:0] S_PC_OUT  = 14'h2000, S_PC_INC = 14'h1000, S_PC_LOAD = 14'h0800;
  localparam logic [13:0] S_MAR     = 14'h0400, S_RAM_OUT = 14'h0200, S_RAM_WE = 14'h0100;
  localparam logic [13:0] S_IR_LOAD = 14'h0080, S_IR_OUT = 14'h0040, S_A_LOAD = 14'h0020;
  localparam logic [13:0] S_A_EN    = 14'h0010, S_B_LOAD = 14'h0008, S_ALU_EN = 14'h0004;
  localparam logic [13:0] S_ALU_SUB = 14'h0002, S_OUT_LOAD = 14'h0001;

  localparam logic [13:0] FETCH0 = S_PC_OUT | S_MAR;
  localparam logic [13:0] FETCH1 = S_RAM_OUT | S_IR_LOAD | S_PC_INC;

`ifdef SAP_SEQ_SKIP_EN
  localparam int LAST_LDA = 3, LAST_ADD = 4, LAST_SUB = 4, LAST_LDI = 2;
`else
  localparam int LAST_LDA = 4, LAST_ADD = 4, LAST_SUB = 4, LAST_LDI = 4;
`endif

  logic [13:0] strobes;
  assign strobes = {pc_out, pc_inc, pc_load, mar_load, ram_out, ram_write_enable, ir_load,
                    ir_out, reg_a_load, reg_a_enable, reg_b_load, alu_enable, alu_subtract, out_load};

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=0x%0h expected=0x%0h", tag, got, exp);
    end
  endtask

  task automatic cycle();
    @(posedge clk);
    #2;
  endtask

  task automatic check_bus(input string tag);
    int drivers;
    drivers = int'(pc_out) + int'(ram_out) + int'(ir_out) + int'(reg_a_enable) + int'(alu_enable);
    check({tag, "_bus_drivers_le1"}, 32'(drivers <= 1), 32'd1);
    check({tag, "_we_vs_ram_out"}, 32'(ram_write_enable & ram_out), 32'd0);
    check({tag, "_sub_needs_alu"}, 32'(alu_subtract & ~alu_enable), 32'd0);
  endtask

  // Runs one instruction from T0 and expects step to return to T0 after step 'last'.
  task automatic run_instr(input string tag, input logic [3:0] op, input logic [13:0] e2,
                           input logic [13:0] e3, input logic [13:0] e4, input int last);
    logic [13:0] exp_vec [5];
    exp_vec = '{FETCH0, FETCH1, e2, e3, e4};
    opcode = op;
    #1;
    for (int i = 0; i <= last; i++) begin
      check($sformatf("%s_step_T%0d", tag, i), 32'(step), i);
      check($sformatf("%s_strobes_T%0d", tag, i), 32'(strobes), 32'(exp_vec[i]));
      check_bus($sformatf("%s_T%0d", tag, i));
      $display("txn %s step=%0d strobes=0x%04h", tag, step, strobes);
      cycle();
    end
    check({tag, "_wrap_T0"}, 32'(step), 32'd0);
  endtask

  initial begin
    reset  = 1'b1;
    run    = 1'b1;
    opcode = 4'h1;

    // Reset held two clocks
    for (int i = 0; i < 2; i++) begin
      cycle();
      check("rst_step", 32'(step), 32'd0);
      check("rst_halted", 32'(halted), 32'd0);
      check("rst_strobes", 32'(strobes), 32'd0);
    end
    reset = 1'b0;
    #1;
    check("post_rst_fetch", 32'(strobes), 32'(FETCH0));
    $display("txn reset step=%0d halted=%0d strobes=0x%04h", step, halted, strobes);

    run_instr("lda", 4'h1, S_IR_OUT | S_MAR, S_RAM_OUT | S_A_LOAD, 14'h0, LAST_LDA);
    run_instr("sub", 4'h3, S_IR_OUT | S_MAR, S_RAM_OUT | S_B_LOAD,
              S_ALU_EN | S_ALU_SUB | S_A_LOAD, LAST_SUB);

    // HLT: fetch, empty T2, then frozen
    opcode = 4'hF;
    #1;
    check("hlt_T0", 32'(strobes), 32'(FETCH0));
    cycle();
    check("hlt_T1", 32'(strobes), 32'(FETCH1));
    cycle();
    check("hlt_T2_step", 32'(step), 32'd2);
    check("hlt_T2_strobes", 32'(strobes), 32'd0);
    check("hlt_T2_not_yet", 32'(halted), 32'd0);
    for (int i = 0; i < 20; i++) begin
      cycle();
      check($sformatf("hlt_frozen_step_%0d", i), 32'(step), 32'd2);
      check($sformatf("hlt_frozen_halted_%0d", i), 32'(halted), 32'd1);
      check($sformatf("hlt_frozen_strobes_%0d", i), 32'(strobes), 32'd0);
    end
    $display("txn hlt step=%0d halted=%0d", step, halted);
    reset = 1'b1;
    cycle();
    check("hlt_rst_step", 32'(step), 32'd0);
    check("hlt_rst_halted", 32'(halted), 32'd0);
    reset = 1'b0;

    // ADD with stall at T3, then reset at T4
    opcode = 4'h2;
    cycle();
    cycle();
    cycle();
    check("stall_at_T3", 32'(step), 32'd3);
    check("stall_T3_strobes", 32'(strobes), 32'(S_RAM_OUT | S_B_LOAD));
    run = 1'b0;
    #1;
    check("stall_strobes_off", 32'(strobes), 32'd0);
    for (int i = 0; i < 3; i++) begin
      cycle();
      check($sformatf("stall_hold_%0d", i), 32'(step), 32'd3);
      check($sformatf("stall_quiet_%0d", i), 32'(strobes), 32'd0);
    end
    run = 1'b1;
    #1;
    check("resume_T3_strobes", 32'(strobes), 32'(S_RAM_OUT | S_B_LOAD));
    cycle();
    check("resume_T4_step", 32'(step), 32'd4);
    check("resume_T4_strobes", 32'(strobes), 32'(S_ALU_EN | S_A_LOAD));
    $display("txn stall step=%0d strobes=0x%04h", step, strobes);
    reset = 1'b1;
    #1;
    check("midop_rst_gated", 32'(strobes), 32'd0);
    cycle();
    reset = 1'b0;
    #1;
    check("midop_rst_step", 32'(step), 32'd0);
    check("midop_rst_no_alu", 32'(alu_enable), 32'd0);
    check("midop_rst_fetch", 32'(strobes), 32'(FETCH0));

    // Back-to-back instructions
    run_instr("ldi", 4'h5, S_IR_OUT | S_A_LOAD, 14'h0, 14'h0, LAST_LDI);
    run_instr("lda2", 4'h1, S_IR_OUT | S_MAR, S_RAM_OUT | S_A_LOAD, 14'h0, LAST_LDA);
    run_instr("add", 4'h2, S_IR_OUT | S_MAR, S_RAM_OUT | S_B_LOAD, S_ALU_EN | S_A_LOAD, LAST_ADD);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout got=running expected=finished");
    $fatal(1, "timeout");
  end

endmodule
